// File: rtl/mips_exception_return_unit_pkg.sv
// Shared CP0 constants, state encoding and cause-code helper for the exception return unit.
package mips_exception_return_unit_pkg;

    // CP0 register numbers visible to MFC0
    localparam logic [4:0] Cp0Status = 5'd12;
    localparam logic [4:0] Cp0Cause  = 5'd13;
    localparam logic [4:0] Cp0Epc    = 5'd14;
    localparam logic [4:0] Cp0Count  = 5'd22;

    // Cause.ExcCode values
    localparam logic [4:0] ExcNone = 5'd0;
    localparam logic [4:0] ExcRi   = 5'd10;
    localparam logic [4:0] ExcOv   = 5'd12;

    // Status bit positions
    localparam int unsigned StatusExlBit = 1;
    localparam int unsigned StatusDfBit  = 2;

    typedef enum logic {
        StRun,
        StHandler
    } state_e;

    // Reserved-instruction outranks overflow, mirroring the vector priority upstream.
    function automatic logic [4:0] exc_code_f(input logic unknown_opcode, input logic overflow);
        if (unknown_opcode) begin
            return ExcRi;
        end else if (overflow) begin
            return ExcOv;
        end
        return ExcNone;
    endfunction

endpackage

// File: rtl/mips_exception_return_unit_if.sv
// Bundle between the core (exception controller, decoder, PC logic) and the return unit.
interface mips_exception_return_unit_if #(
    parameter int unsigned WSIZE = 32
);
    logic             exception;
    logic [WSIZE-1:0] exception_ADDR;
    logic             unknown_opcode;
    logic             overflow;
    logic [WSIZE-1:0] pc_current;
    logic             eret;
    logic [4:0]       mfc0_sel;
    logic [WSIZE-1:0] pc_redirect;
    logic             pc_redirect_valid;
    logic             in_handler;
    logic [WSIZE-1:0] epc;
    logic [WSIZE-1:0] mfc0_data;

    // Core side
    modport master (
        output exception, exception_ADDR, unknown_opcode, overflow, pc_current, eret, mfc0_sel,
        input  pc_redirect, pc_redirect_valid, in_handler, epc, mfc0_data
    );

    // Return unit side
    modport slave (
        input  exception, exception_ADDR, unknown_opcode, overflow, pc_current, eret, mfc0_sel,
        output pc_redirect, pc_redirect_valid, in_handler, epc, mfc0_data
    );
endinterface

// File: rtl/mips_cp0_regfile.sv
// EPC, Cause, sticky double-fault flag and saturating exception counter, plus the MFC0 read mux.
module mips_cp0_regfile
    import mips_exception_return_unit_pkg::*;
#(
    parameter int unsigned WSIZE = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             exc_i,       // exception taken this cycle
    input  logic             epc_we_i,    // capture pc_i into EPC
    input  logic [WSIZE-1:0] pc_i,
    input  logic [4:0]       exc_code_i,
    input  logic             df_set_i,
    input  logic             exl_i,       // Status.EXL, owned by the top-level FSM
    input  logic [4:0]       mfc0_sel_i,
    output logic [WSIZE-1:0] epc_o,
    output logic [WSIZE-1:0] mfc0_data_o
);

    logic [WSIZE-1:0] epc_q, epc_d;
    logic [4:0]       code_q, code_d;
    logic             df_q, df_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WSIZE-1:0] status, cause;

    // Next-state for the architectural CP0 registers
    always_comb begin
        epc_d  = epc_q;
        code_d = code_q;
        df_d   = df_q;
        cnt_d  = cnt_q;
        if (epc_we_i) begin
            epc_d = pc_i;
        end
        if (exc_i) begin
            code_d = exc_code_i;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (df_set_i) begin
            df_d = 1'b1;
        end
    end

    // CP0 register flops
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            epc_q  <= '0;
            code_q <= ExcNone;
            df_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            epc_q  <= epc_d;
            code_q <= code_d;
            df_q   <= df_d;
            cnt_q  <= cnt_d;
        end
    end

    // MFC0 read mux; returns pre-edge values
    always_comb begin
        status               = '0;
        status[StatusExlBit] = exl_i;
        status[StatusDfBit]  = df_q;
        cause                = '0;
        cause[6:2]           = code_q;
        unique case (mfc0_sel_i)
            Cp0Status: mfc0_data_o = status;
            Cp0Cause:  mfc0_data_o = cause;
            Cp0Epc:    mfc0_data_o = epc_q;
            Cp0Count:  mfc0_data_o = WSIZE'(cnt_q);
            default:   mfc0_data_o = '0;
        endcase
    end

    assign epc_o = epc_q;

endmodule

// File: rtl/mips_exception_return_unit.sv
// Exception entry / ERET state machine and zero-latency PC redirect for the single-cycle core.
module mips_exception_return_unit
    import mips_exception_return_unit_pkg::*;
#(
    parameter int unsigned WSIZE = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    mips_exception_return_unit_if.slave   bus
);

    state_e           state_q;
    logic             take_exc, take_eret, epc_we, df_set;
    logic [4:0]       exc_code;
    logic [WSIZE-1:0] epc;

    // Event decode: exception always wins, ERET only counts inside a handler
    always_comb begin
        take_exc  = bus.exception;
        take_eret = bus.eret && !bus.exception && (state_q == StHandler);
        epc_we    = take_exc && (state_q == StRun);
        df_set    = take_exc && (state_q == StHandler);
        exc_code  = exc_code_f(bus.unknown_opcode, bus.overflow);
    end

    // Redirect mux, suppressed while reset is held
    always_comb begin
        bus.pc_redirect_valid = rst_n && (take_exc || take_eret);
        bus.pc_redirect       = '0;
        if (rst_n) begin
            if (take_exc) begin
                bus.pc_redirect = bus.exception_ADDR;
            end else if (take_eret) begin
                bus.pc_redirect = epc;
            end
        end
    end

    // RUN/HANDLER state machine; the state itself is Status.EXL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            unique case (state_q)
                StRun:     if (take_exc) state_q <= StHandler;
                StHandler: if (take_eret) state_q <= StRun;
                default:   state_q <= StRun;
            endcase
        end
    end

    assign bus.in_handler = (state_q == StHandler);
    assign bus.epc        = epc;

    mips_cp0_regfile #(
        .WSIZE (WSIZE),
        .CNT_W (CNT_W)
    ) u_cp0_regfile (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .exc_i       (take_exc),
        .epc_we_i    (epc_we),
        .pc_i        (bus.pc_current),
        .exc_code_i  (exc_code),
        .df_set_i    (df_set),
        .exl_i       (bus.in_handler),
        .mfc0_sel_i  (bus.mfc0_sel),
        .epc_o       (epc),
        .mfc0_data_o (bus.mfc0_data)
    );

endmodule
